// File: rtl/pifo_tb_headers.sv
// Shared types for the PIFO testbench run-control blocks.
package pifo_tb_headers;

    localparam int COUNTER_WIDTH = 16;

    typedef logic [COUNTER_WIDTH-1:0] CounterSignal;

    typedef enum logic [2:0] {
        PHASE_IDLE     = 3'd0,
        PHASE_WARMUP   = 3'd1,
        PHASE_GENERATE = 3'd2,
        PHASE_DRAIN    = 3'd3,
        PHASE_DONE     = 3'd4
    } PhaseState;

    function automatic CounterSignal sat_inc(input CounterSignal value, input logic inc);
        if (inc && (value != '1)) begin
            return value + CounterSignal'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/saturating_counter.sv
// Synchronously clearable up-counter that sticks at all-ones.
module saturating_counter
    import pifo_tb_headers::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         inc_i,
    output CounterSignal value_o
);

    CounterSignal value_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            value_q <= '0;
        end else begin
            value_q <= sat_inc(value_q, inc_i);
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/pifo_tb_phase_controller.sv
// Run-control FSM for the PIFO traffic bench: warm-up, generate, drain, done,
// plus per-run enqueue/dequeue tallies with timeout and underflow flags.
//
// state    | meaning
// IDLE     | waiting for the first start pulse, counters frozen at 0
// WARMUP   | settling period before traffic generation
// GENERATE | generator enabled for GENERATE_CYCLES cycles
// DRAIN    | waiting for PIFO to empty and tallies to match, or timeout
// DONE     | run finished; start pulse begins a new run
module pifo_tb_phase_controller
    import pifo_tb_headers::*;
#(
    parameter int WARMUP_CYCLES   = 16,
    parameter int GENERATE_CYCLES = 1024,
    parameter int DRAIN_TIMEOUT   = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i__start,
    input  logic         i__pkt_enqueued,
    input  logic         i__pkt_dequeued,
    input  logic         i__pifo_empty,
    output logic         o__generate_phase,
    output CounterSignal o__phase_count,
    output logic         o__drain_phase,
    output logic         o__done,
    output logic         o__timeout,
    output logic         o__underflow,
    output CounterSignal o__enq_count,
    output CounterSignal o__deq_count,
    output PhaseState    o__state
);

    localparam CounterSignal WARMUP_LAST   = CounterSignal'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
    localparam CounterSignal GENERATE_LAST = CounterSignal'(GENERATE_CYCLES - 1);
    localparam CounterSignal DRAIN_LAST    = CounterSignal'(DRAIN_TIMEOUT - 1);
    localparam PhaseState    FIRST_PHASE   = (WARMUP_CYCLES == 0) ? PHASE_GENERATE : PHASE_WARMUP;

    PhaseState    state_q, state_d;
    logic         generate_q, drain_q, done_q;
    logic         timeout_q, timeout_d;
    logic         underflow_q, underflow_d;

    CounterSignal phase_count, enq_count, deq_count;
    CounterSignal enq_nxt, deq_nxt;
    logic         start_run, counting, enq_inc, deq_inc, drain_complete, phase_clear;

    always_comb begin
        start_run      = i__start && ((state_q == PHASE_IDLE) || (state_q == PHASE_DONE));
        counting       = ((state_q == PHASE_WARMUP) || (state_q == PHASE_GENERATE) ||
                          (state_q == PHASE_DRAIN)  || (state_q == PHASE_DONE)) && !start_run;
        enq_inc        = counting && i__pkt_enqueued;
        deq_inc        = counting && i__pkt_dequeued;
        // Completion looks at the tallies as they will be after this cycle's strobes.
        enq_nxt        = sat_inc(enq_count, enq_inc);
        deq_nxt        = sat_inc(deq_count, deq_inc);
        drain_complete = i__pifo_empty && (enq_nxt == deq_nxt);

        state_d     = state_q;
        timeout_d   = timeout_q;
        underflow_d = underflow_q ||
                      (deq_inc && !i__pkt_enqueued && (enq_count == deq_count));

        case (state_q)
            PHASE_IDLE: begin
                if (i__start) state_d = FIRST_PHASE;
            end
            PHASE_WARMUP: begin
                if (phase_count == WARMUP_LAST) state_d = PHASE_GENERATE;
            end
            PHASE_GENERATE: begin
                if (phase_count == GENERATE_LAST) state_d = PHASE_DRAIN;
            end
            PHASE_DRAIN: begin
                if (drain_complete) begin
                    state_d = PHASE_DONE;
                end else if (phase_count == DRAIN_LAST) begin
                    state_d   = PHASE_DONE;
                    timeout_d = 1'b1;
                end
            end
            PHASE_DONE: begin
                if (i__start) state_d = FIRST_PHASE;
            end
            default: state_d = PHASE_IDLE;
        endcase

        if (start_run) begin
            timeout_d   = 1'b0;
            underflow_d = 1'b0;
        end

        phase_clear = (state_d != state_q) || (state_d == PHASE_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PHASE_IDLE;
            generate_q  <= 1'b0;
            drain_q     <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            generate_q  <= (state_d == PHASE_GENERATE);
            drain_q     <= (state_d == PHASE_DRAIN);
            done_q      <= (state_d == PHASE_DONE);
            timeout_q   <= timeout_d;
            underflow_q <= underflow_d;
        end
    end

    saturating_counter u_phase_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (phase_clear),
        .inc_i   (1'b1),
        .value_o (phase_count)
    );

    saturating_counter u_enq_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (start_run),
        .inc_i   (enq_inc),
        .value_o (enq_count)
    );

    saturating_counter u_deq_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (start_run),
        .inc_i   (deq_inc),
        .value_o (deq_count)
    );

    assign o__generate_phase = generate_q;
    assign o__drain_phase    = drain_q;
    assign o__done           = done_q;
    assign o__timeout        = timeout_q;
    assign o__underflow      = underflow_q;
    assign o__phase_count    = phase_count;
    assign o__enq_count      = enq_count;
    assign o__deq_count      = deq_count;
    assign o__state          = state_q;

endmodule

// File: tb/tb_pifo_tb_phase_controller.sv
// Directed bench for pifo_tb_phase_controller: one DUT with a warm-up phase,
// one with warm-up disabled, sharing the same stimulus.
module tb_pifo_tb_phase_controller;
    import pifo_tb_headers::*;

    logic clk = 1'b0;
    logic reset, start, enq, deq, empty;

    logic         a_gen, a_drain, a_done, a_to, a_uf;
    CounterSignal a_phase, a_enq, a_deq;
    PhaseState    a_state;

    logic         b_gen, b_drain, b_done, b_to, b_uf;
    CounterSignal b_phase, b_enq, b_deq;
    PhaseState    b_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pifo_tb_phase_controller #(.WARMUP_CYCLES(4), .GENERATE_CYCLES(8), .DRAIN_TIMEOUT(10)) dut_a (
        .clk(clk), .reset(reset), .i__start(start), .i__pkt_enqueued(enq),
        .i__pkt_dequeued(deq), .i__pifo_empty(empty),
        .o__generate_phase(a_gen), .o__phase_count(a_phase), .o__drain_phase(a_drain),
        .o__done(a_done), .o__timeout(a_to), .o__underflow(a_uf),
        .o__enq_count(a_enq), .o__deq_count(a_deq), .o__state(a_state)
    );

    pifo_tb_phase_controller #(.WARMUP_CYCLES(0), .GENERATE_CYCLES(8), .DRAIN_TIMEOUT(10)) dut_b (
        .clk(clk), .reset(reset), .i__start(start), .i__pkt_enqueued(enq),
        .i__pkt_dequeued(deq), .i__pifo_empty(empty),
        .o__generate_phase(b_gen), .o__phase_count(b_phase), .o__drain_phase(b_drain),
        .o__done(b_done), .o__timeout(b_to), .o__underflow(b_uf),
        .o__enq_count(b_enq), .o__deq_count(b_deq), .o__state(b_state)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (a_state !== PHASE_IDLE) $display("FAIL reset_state: got %0d want 0", a_state); else n_pass++;
        n_checks++; if ({a_gen, a_drain, a_done, a_to, a_uf} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {a_gen, a_drain, a_done, a_to, a_uf}); else n_pass++;
        n_checks++; if ({a_phase, a_enq, a_deq} !== '0) $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", a_phase, a_enq, a_deq); else n_pass++;
        enq = 1'b1; deq = 1'b1;
        tick(2);
        enq = 1'b0; deq = 1'b0;
        n_checks++; if ({a_state, a_phase, a_enq, a_deq, a_uf} !== '0) $display("FAIL idle_frozen: state %0d phase %0d enq %0d deq %0d uf %b want all 0", a_state, a_phase, a_enq, a_deq, a_uf); else n_pass++;
    endtask

    task automatic test_basic();
        empty = 1'b1;
        pulse_start();
        n_checks++; if (a_state !== PHASE_WARMUP || a_phase !== 16'd0) $display("FAIL basic_warmup_entry: state %0d phase %0d want 1/0", a_state, a_phase); else n_pass++;
        tick(3);
        n_checks++; if (a_state !== PHASE_WARMUP || a_phase !== 16'd3) $display("FAIL basic_warmup_last: state %0d phase %0d want 1/3", a_state, a_phase); else n_pass++;
        tick(1);
        n_checks++; if (a_state !== PHASE_GENERATE || a_gen !== 1'b1 || a_phase !== 16'd0) $display("FAIL basic_gen_entry: state %0d gen %b phase %0d want 2/1/0", a_state, a_gen, a_phase); else n_pass++;
        tick(7);
        n_checks++; if (a_state !== PHASE_GENERATE || a_gen !== 1'b1 || a_phase !== 16'd7) $display("FAIL basic_gen_last: state %0d gen %b phase %0d want 2/1/7", a_state, a_gen, a_phase); else n_pass++;
        tick(1);
        n_checks++; if (a_state !== PHASE_DRAIN || a_drain !== 1'b1 || a_gen !== 1'b0 || a_phase !== 16'd0) $display("FAIL basic_drain_entry: state %0d drain %b gen %b phase %0d want 3/1/0/0", a_state, a_drain, a_gen, a_phase); else n_pass++;
        tick(1);
        n_checks++; if (a_state !== PHASE_DONE || a_done !== 1'b1 || a_to !== 1'b0 || a_drain !== 1'b0) $display("FAIL basic_done: state %0d done %b timeout %b drain %b want 4/1/0/0", a_state, a_done, a_to, a_drain); else n_pass++;
        tick(1);
        n_checks++; if (a_state !== PHASE_DONE || a_phase !== 16'd1) $display("FAIL basic_done_count: state %0d phase %0d want 4/1", a_state, a_phase); else n_pass++;
    endtask

    task automatic test_balanced();
        empty = 1'b0;
        pulse_start();
        n_checks++; if (a_state !== PHASE_WARMUP || a_done !== 1'b0) $display("FAIL bal_restart: state %0d done %b want 1/0", a_state, a_done); else n_pass++;
        tick(4);
        enq = 1'b1;
        tick(5);
        enq = 1'b0;
        n_checks++; if (a_enq !== 16'd5 || a_phase !== 16'd5) $display("FAIL bal_enq: enq %0d phase %0d want 5/5", a_enq, a_phase); else n_pass++;
        tick(3);
        n_checks++; if (a_state !== PHASE_DRAIN) $display("FAIL bal_drain_entry: state %0d want 3", a_state); else n_pass++;
        deq = 1'b1;
        tick(5);
        deq = 1'b0;
        n_checks++; if (a_state !== PHASE_DRAIN || a_deq !== 16'd5) $display("FAIL bal_not_empty_hold: state %0d deq %0d want 3/5", a_state, a_deq); else n_pass++;
        empty = 1'b1;
        tick(1);
        n_checks++; if (a_state !== PHASE_DONE || a_enq !== 16'd5 || a_deq !== 16'd5 || a_to !== 1'b0 || a_uf !== 1'b0) $display("FAIL bal_done: state %0d enq %0d deq %0d to %b uf %b want 4/5/5/0/0", a_state, a_enq, a_deq, a_to, a_uf); else n_pass++;
    endtask

    task automatic test_timeout();
        empty = 1'b0;
        pulse_start();
        n_checks++; if (a_enq !== 16'd0 || a_deq !== 16'd0) $display("FAIL to_restart_clear: enq %0d deq %0d want 0/0", a_enq, a_deq); else n_pass++;
        tick(4);
        enq = 1'b1;
        tick(3);
        enq = 1'b0;
        tick(5);
        n_checks++; if (a_state !== PHASE_DRAIN || a_phase !== 16'd0 || a_enq !== 16'd3) $display("FAIL to_drain_entry: state %0d phase %0d enq %0d want 3/0/3", a_state, a_phase, a_enq); else n_pass++;
        tick(9);
        n_checks++; if (a_state !== PHASE_DRAIN || a_phase !== 16'd9 || a_to !== 1'b0) $display("FAIL to_drain_last: state %0d phase %0d to %b want 3/9/0", a_state, a_phase, a_to); else n_pass++;
        tick(1);
        n_checks++; if (a_state !== PHASE_DONE || a_to !== 1'b1 || a_enq !== 16'd3 || a_deq !== 16'd0) $display("FAIL to_done: state %0d to %b enq %0d deq %0d want 4/1/3/0", a_state, a_to, a_enq, a_deq); else n_pass++;
        tick(1);
        n_checks++; if (a_to !== 1'b1) $display("FAIL to_sticky: to %b want 1", a_to); else n_pass++;
    endtask

    task automatic test_underflow();
        empty = 1'b1;
        pulse_start();
        n_checks++; if (a_to !== 1'b0 || a_state !== PHASE_WARMUP) $display("FAIL uf_restart_to_clear: to %b state %0d want 0/1", a_to, a_state); else n_pass++;
        deq = 1'b1;
        tick(1);
        deq = 1'b0;
        n_checks++; if (a_uf !== 1'b1 || a_deq !== 16'd1 || a_enq !== 16'd0) $display("FAIL uf_set: uf %b deq %0d enq %0d want 1/1/0", a_uf, a_deq, a_enq); else n_pass++;
        tick(3);
        enq = 1'b1;
        tick(1);
        enq = 1'b0;
        n_checks++; if (a_state !== PHASE_GENERATE || a_uf !== 1'b1 || a_enq !== 16'd1) $display("FAIL uf_sticky: state %0d uf %b enq %0d want 2/1/1", a_state, a_uf, a_enq); else n_pass++;
        tick(7);
        n_checks++; if (a_state !== PHASE_DRAIN) $display("FAIL uf_drain: state %0d want 3", a_state); else n_pass++;
        tick(1);
        n_checks++; if (a_state !== PHASE_DONE || a_uf !== 1'b1 || a_to !== 1'b0) $display("FAIL uf_done: state %0d uf %b to %b want 4/1/0", a_state, a_uf, a_to); else n_pass++;
        enq = 1'b1;
        pulse_start();
        enq = 1'b0;
        n_checks++; if (a_uf !== 1'b0 || a_deq !== 16'd0 || a_enq !== 16'd0) $display("FAIL uf_restart_clear: uf %b deq %0d enq %0d want 0/0/0", a_uf, a_deq, a_enq); else n_pass++;
    endtask

    task automatic test_warmup0();
        empty = 1'b0;
        do_reset();
        pulse_start();
        n_checks++; if (b_state !== PHASE_GENERATE || b_gen !== 1'b1 || b_phase !== 16'd0) $display("FAIL w0_direct_gen: state %0d gen %b phase %0d want 2/1/0", b_state, b_gen, b_phase); else n_pass++;
        tick(7);
        n_checks++; if (b_state !== PHASE_GENERATE || b_phase !== 16'd7) $display("FAIL w0_gen_last: state %0d phase %0d want 2/7", b_state, b_phase); else n_pass++;
        tick(1);
        n_checks++; if (b_state !== PHASE_DRAIN || b_drain !== 1'b1) $display("FAIL w0_drain: state %0d drain %b want 3/1", b_state, b_drain); else n_pass++;
    endtask

    task automatic test_reset_mid();
        empty = 1'b0;
        do_reset();
        pulse_start();
        tick(6);
        n_checks++; if (a_state !== PHASE_GENERATE || a_phase !== 16'd2) $display("FAIL mid_gen: state %0d phase %0d want 2/2", a_state, a_phase); else n_pass++;
        start = 1'b1; enq = 1'b1;
        tick(1);
        start = 1'b0; enq = 1'b0;
        n_checks++; if (a_state !== PHASE_GENERATE || a_phase !== 16'd3 || a_enq !== 16'd1) $display("FAIL mid_start_ignored: state %0d phase %0d enq %0d want 2/3/1", a_state, a_phase, a_enq); else n_pass++;
        do_reset();
        n_checks++; if ({a_state, a_gen, a_drain, a_done, a_to, a_uf, a_phase, a_enq, a_deq} !== '0) $display("FAIL mid_reset: state %0d gen %b phase %0d enq %0d deq %0d want all 0", a_state, a_gen, a_phase, a_enq, a_deq); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; enq = 1'b0; deq = 1'b0; empty = 1'b0;
        tick(2);
        test_reset();
        test_basic();
        test_balanced();
        test_timeout();
        test_underflow();
        test_warmup0();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
